// File: rtl/rail_fence_encrypt.sv
// rail_fence_encrypt
//   Buffers a plaintext byte stream (closed by TERM, or cut at MAX_LEN
//   bytes) and re-emits it in rail-fence (zig-zag) order for 1, 2 or 3
//   rails, followed by a single TERM byte.
//
// Ports
//   clk      : single rising-edge clock
//   reset    : synchronous, active-high
//   data_i   : plaintext byte
//   valid_i  : data_i valid this cycle (ignored while busy)
//   key      : rail select, sampled with the first byte of a message
//              (2'b10 -> 2 rails, 2'b11 -> 3 rails, otherwise 1 rail)
//   data_o   : ciphertext byte (registered)
//   valid_o  : data_o valid (registered)
//   busy     : not accepting input (registered)
module rail_fence_encrypt #(
  parameter int          MAX_LEN = 50,
  parameter logic [7:0]  TERM    = 8'hFA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic [1:0] key,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy
);

  // One spare bit so ptr + step can never wrap.
  localparam int IW = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_TERM = 2'd2;

  // Source select for the registered output byte.
  localparam logic [1:0] OUT_HOLD = 2'd0;
  localparam logic [1:0] OUT_MEM  = 2'd1;
  localparam logic [1:0] OUT_TERM = 2'd2;
  localparam logic [1:0] OUT_BYP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic [1:0]    rails_q, rails_d;
  logic [1:0]    rail_q, rail_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] step_q, step_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [7:0]    data_q;

  logic [7:0]    mem_q [MAX_LEN];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [1:0]    out_sel;

  logic [1:0]    key_rails;
  logic [IW-1:0] p_cur;
  logic [IW-1:0] sum;
  logic [1:0]    nrail;
  logic [IW-1:0] nrail_w;
  logic          edge_rail;

  // Zig-zag period; a single rail degenerates to a unit stride.
  function automatic logic [IW-1:0] period_of(input logic [1:0] r);
    if (r <= 2'd1) return IW'(1);
    return IW'({r - 2'd1, 1'b0});
  endfunction

  assign key_rails = key[1] ? (key[0] ? 2'd3 : 2'd2) : 2'd1;
  assign p_cur     = period_of(rails_q);
  assign sum       = ptr_q + step_q;
  assign nrail     = rail_q + 2'd1;
  assign nrail_w   = IW'(nrail);
  assign edge_rail = (rail_q == 2'd0) || (rail_q == rails_q - 2'd1);
  assign wr_addr   = len_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rails_d = rails_q;
    rail_d  = rail_q;
    ptr_d   = ptr_q;
    step_d  = step_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    rd_addr = '0;
    out_sel = OUT_HOLD;

    case (state_q)
      S_LOAD: begin
        if (valid_i) begin
          if (data_i == TERM) begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (len_q == '0) begin
              state_d = S_TERM;
              out_sel = OUT_TERM;
            end else begin
              // Rail 0 always starts at index 0.
              state_d = S_EMIT;
              rail_d  = 2'd0;
              ptr_d   = '0;
              step_d  = p_cur;
              out_sel = OUT_MEM;
            end
          end else begin
            wr_en = 1'b1;
            len_d = len_q + IW'(1);
            if (len_q == '0) rails_d = key_rails;
            if (len_q + IW'(1) == IW'(MAX_LEN)) begin
              state_d = S_EMIT;
              valid_d = 1'b1;
              busy_d  = 1'b1;
              rail_d  = 2'd0;
              ptr_d   = '0;
              step_d  = period_of(rails_d);
              // Byte 0 is still on data_i only when the buffer is one deep.
              out_sel = (len_q == '0) ? OUT_BYP : OUT_MEM;
            end
          end
        end
      end

      S_EMIT: begin
        if (sum < len_q) begin
          ptr_d   = sum;
          // Middle rails alternate two strides that always sum to P.
          step_d  = edge_rail ? step_q : (p_cur - step_q);
          rd_addr = AW'(sum);
          out_sel = OUT_MEM;
        end else if ((nrail < rails_q) && (nrail_w < len_q)) begin
          rail_d  = nrail;
          ptr_d   = nrail_w;
          step_d  = (nrail == rails_q - 2'd1) ? p_cur : (p_cur - (nrail_w << 1));
          rd_addr = AW'(nrail_w);
          out_sel = OUT_MEM;
        end else begin
          // Later rails start even further out, so all are empty.
          state_d = S_TERM;
          out_sel = OUT_TERM;
        end
      end

      S_TERM: begin
        state_d = S_LOAD;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        len_d   = '0;
      end

      default: begin
        state_d = S_LOAD;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      len_q   <= '0;
      rails_q <= '0;
      rail_q  <= '0;
      ptr_q   <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rails_q <= rails_d;
      rail_q  <= rail_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Payload buffer: contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= 8'h00;
    end else begin
      case (out_sel)
        OUT_MEM:  data_q <= mem_q[rd_addr];
        OUT_TERM: data_q <= TERM;
        OUT_BYP:  data_q <= data_i;
        default:  data_q <= data_q;
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;

endmodule

// File: doc/rail_fence_encrypt.md
# rail_fence_encrypt

Upstream companion of the rail-fence decryption stage. Buffers a plaintext byte stream of up to `MAX_LEN` bytes, closed by a terminator byte. Re-emits the bytes in rail-fence (zig-zag) order for 1, 2 or 3 rails, then appends the terminator. Its output stream is the ciphertext format the decryption stage consumes.

## Interface
- `MAX_LEN`, 50: buffer depth in bytes; a message longer than this is cut at `MAX_LEN`.
- `TERM`, 8'hFA: end-of-message byte. It is never stored as payload.
- `clk` input 1: single clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `data_i` input 8: plaintext byte.
- `valid_i` input 1: `data_i` is valid this cycle.
- `key` input 2: rail select. 2'b10 gives 2 rails, 2'b11 gives 3 rails, 2'b00 and 2'b01 give 1 rail (pass-through). Sampled with the first byte of each message.
- `data_o` output 8: ciphertext byte, registered.
- `valid_o` output 1: `data_o` is valid this cycle, registered.
- `busy` output 1: block is not accepting input, registered.

## Operation
- States:
  - `LOAD`: the reset state.
  - `EMIT`: streams payload bytes.
  - `TERM_OUT`: sends the terminator for one cycle, then returns to `LOAD`.
- Reset values:
  - State is `LOAD`.
  - Length, rail, pointer and step are 0.
  - `data_o` = 8'h00, `valid_o` = 0, `busy` = 0.
  - Buffer contents are don't-care.
- In `LOAD`, with `valid_i` = 1:
  - If `data_i` != `TERM`: store the byte at `buf[len]` and increment `len`. If `len` was 0, also latch `key` into `rails` (1, 2 or 3).
  - If `data_i` == `TERM`: go to `EMIT`, or straight to `TERM_OUT` if `len` = 0.
  - If the byte stored makes `len` equal `MAX_LEN`: go to `EMIT` as if `TERM` had arrived. A `TERM` byte sent after that is treated as the first byte of the next message and ignored as empty.
- Rail order, with period `P = 2*(rails-1)`; for `rails` = 1, `P` is treated as 1:
  - Rail `r` starts at index `r`.
  - Rails 0 and `rails-1` step by `P`.
  - A middle rail alternates steps `P-2r` and `2r`, starting with `P-2r`.
  - Rails are emitted in order 0 to `rails-1`.
  - When `ptr + step >= len`, move to the next rail.
  - A rail whose start index is `>= len` is skipped with no idle cycle. The next pointer is computed combinationally from the current rail, pointer and length.
- `EMIT` outputs one byte per cycle, exactly `len` cycles, and every index 0..`len`-1 is emitted exactly once. After the last payload byte comes `TERM_OUT`: `data_o` = `TERM`, `valid_o` = 1 for one cycle, then `LOAD` with `len` cleared.
- `busy` = 1 in `EMIT` and `TERM_OUT`. While `busy`, `valid_i` is ignored and input bytes are dropped.
- Reset during any state aborts the message: the reset values apply on the next edge, and no further `valid_o` pulses occur.

## Timing
- The terminator (or the `MAX_LEN`-th byte) is sampled at edge T.
- From edge T, `busy` = 1 and the first ciphertext byte is on `data_o` with `valid_o` = 1. Input-to-output latency is 1 cycle.
- `valid_o` stays high for exactly `len+1` consecutive cycles with no bubbles, the last carrying `TERM`.
- `busy` falls on the same edge that `valid_o` falls. A byte presented in that following cycle is accepted.
- An empty message (`TERM` as first byte): exactly one `valid_o` cycle carrying 8'hFA.
- Index arithmetic uses `$clog2(MAX_LEN)+1` bits so that `ptr + step` never wraps.

## Test plan
- Message "HELLO" (48 45 4C 4C 4F), then FA, `key` = 2'b10 -> `data_o` = 48 4C 4F 45 4C FA ("HLOEL"). `valid_o` high for 6 consecutive cycles starting 1 cycle after FA is sampled.
- Message "WEAREDISCOVERED", then FA, `key` = 2'b11 -> "WECRERDSOEEAIVD", then FA. Exactly 16 valid cycles.
- Message "ABC", then FA, `key` = 2'b00 -> 41 42 43 FA. Also: FA sent alone -> single FA output, `busy` high for 1 cycle.
- 50 bytes 0x00..0x31, no FA, `key` = 2'b10 -> even values 00..30 ascending, then odd values 01..31, then FA. 51 valid cycles, starting 1 cycle after byte 0x31. Bytes driven while `busy` = 1 produce no effect.
- Message 1-2-3 (4 bytes, 3 rails) -> index order 0,1,3,2, then FA. Then immediately a second message "XY" with `key` = 2'b10 -> "XY" FA. This checks the `key` re-latch and `len` clear.
- Assert `reset` during the third `EMIT` cycle -> `valid_o` = 0 and `busy` = 0 on the next edge. A following "AB" FA with `key` = 2'b10 outputs 41 42 FA.
